pwm_sample_decoder: RTL and testbench
=====================================

// Module: pwm_sample_decoder
// PURPOSE
//  Receive end of the synth's 1-bit PWM audio output: recovers the per-period duty (sample value) from a
//  PWM stream. Sits on the bench/loopback path, fed by sigout, producing samples for comparison with the
//  mixer's digital output. Synchronises the pin, aligns to the PWM frame start and emits one sample per period.
// PARAMETERS
//  PERIOD      256  clocks per PWM frame (power of 2, >=4)
//  SAMPLE_W    8    output sample width; log2(PERIOD) == SAMPLE_W
//  SYNC_STAGES 2    synchroniser flops on pwm_in (>=2)
// PORTS
//  hwclk        in   1         system clock, all logic on rising edge
//  nrst         in   1         reset, synchronous, active-low
//  enable       in   1         1 = decode; 0 = return to IDLE
//  pwm_in       in   1         PWM stream (asynchronous to hwclk-domain logic, synchronised internally)
//  sample       out  SAMPLE_W  last decoded duty, held between strobes
//  sample_valid out  1         1-cycle strobe, sample updated this cycle
//  locked       out  1         frame alignment established (>=1 complete clean frame)
//  phase_err    out  1         sticky: rising edge seen mid-frame; cleared by reset or enable=0
// BEHAVIOUR
//  Reset (nrst=0 at posedge): state=IDLE, sample=0, sample_valid=0, locked=0, phase_err=0, pos=0,
//    high_cnt=0, synchroniser and edge-history flops=0. Reset mid-frame discards the partial frame.
//  Input path: s = pwm_in after SYNC_STAGES flops; rise = s & ~s_d (s_d = s delayed one cycle).
//  States: IDLE -> SEEK when enable=1. SEEK -> TRACK on rise (that cycle is frame pos 0).
//    any state -> IDLE when enable=0 (same-cycle, no sample emitted, locked and phase_err cleared).
//  TRACK, each cycle: high_cnt accumulates s; pos increments, wraps PERIOD-1 -> 0.
//    At pos==PERIOD-1: total = high_cnt + s (SAMPLE_W+1 bits); sample <= min(total, 2^SAMPLE_W-1);
//      sample_valid pulses next cycle with the new sample; high_cnt restarts at 0; locked <= 1.
//    rise at pos==0: expected frame start, no action.
//    rise at pos!=0: phase_err <= 1, locked <= 0, partial frame discarded (no strobe), frame restarts:
//      pos=0 at that cycle, high_cnt counts from this cycle.
//  Duty 0 (no rise) and duty PERIOD (constant high, no rise) keep TRACK free-running: yield 0 and
//    2^SAMPLE_W-1 (saturated) respectively; neither is an error.
//  Latency: pin edge -> s is SYNC_STAGES cycles; last frame cycle -> sample_valid is 1 cycle.
//  Simultaneous enable=0 and frame end: enable wins, no strobe. sample holds its value in IDLE/SEEK.
//  sample_valid never asserted outside TRACK; strobes at most once per PERIOD cycles.
// STRUCTURE
//  tmnt_pkg: typedef enum logic [1:0] {DEC_IDLE, DEC_SEEK, DEC_TRACK} pwm_dec_state_t;
//    localparam PWM_PERIOD = 256, PWM_SAMPLE_W = 8 (shared with the PWM generator).
//  Sub-module pwm_edge_sync: SYNC_STAGES flop chain + s_d, outputs s and rise.
//  Top: state register, pos counter, high_cnt accumulator, saturating output register, flags.
// TESTING
//  1 enable=1, PWM duty 64/256 repeated 4 frames -> after first rise, sample=64 with sample_valid every
//    256 cycles, locked=1 after first strobe, phase_err=0.
//  2 locked at duty 200, switch to duty 0 then constant high -> samples 200, 0, 255 (saturated), no phase_err.
//  3 locked at duty 100, inject extra rise at pos 50 -> phase_err=1, locked=0, no strobe for that frame,
//    next strobe 256 cycles after the injected rise with its measured duty.
//  4 enable deasserted at pos 128 -> IDLE next cycle, no sample_valid, sample holds 100; re-enable -> SEEK.
//  5 nrst=0 at pos 200 for 1 cycle -> all outputs 0 next cycle; decode resumes via SEEK, first strobe after
//    a full frame.
//  6 enable=0 same cycle as pos==PERIOD-1 -> no strobe; sample unchanged.

Source files
------------

// File: rtl/tmnt_pkg.sv
// Shared PWM audio definitions: decoder state encoding and the frame geometry
// that the PWM generator and the loopback decoder must agree on.
package tmnt_pkg;

  typedef enum logic [1:0] {DEC_IDLE, DEC_SEEK, DEC_TRACK} pwm_dec_state_t;

  localparam int PWM_PERIOD   = 256;
  localparam int PWM_SAMPLE_W = 8;

endpackage

// File: rtl/pwm_sample_decoder_edge_sync.sv
// Brings the asynchronous PWM pin into the hwclk domain and flags rising edges
// of the synchronised level.
module pwm_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_nrst,
  input  logic i_pin,
  output logic o_s,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_sync <= '0;
      r_s_d  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_s_d  <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_s    = r_sync[SYNC_STAGES-1];
  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_s_d;

endmodule

// File: rtl/pwm_sample_decoder.sv
// Recovers one duty-cycle sample per PWM frame from the synth's 1-bit output,
// aligning to frame-start rising edges and flagging edges that arrive mid-frame.
module pwm_sample_decoder
  import tmnt_pkg::*;
#(
  parameter int PERIOD      = PWM_PERIOD,
  parameter int SAMPLE_W    = PWM_SAMPLE_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                hwclk,
  input  logic                nrst,
  input  logic                enable,
  input  logic                pwm_in,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_valid,
  output logic                locked,
  output logic                phase_err
);

  pwm_dec_state_t      r_state, w_next_state;
  logic [SAMPLE_W-1:0] r_pos, r_high_cnt, r_sample;
  logic                r_valid, r_locked, r_perr;

  logic                w_s, w_rise;
  logic                w_active, w_restart, w_frame_end;
  logic [SAMPLE_W-1:0] w_cur_pos, w_base;
  logic [SAMPLE_W:0]   w_total;

  function automatic logic [SAMPLE_W-1:0] sat_sample(input logic [SAMPLE_W:0] total);
    logic [SAMPLE_W-1:0] res;
    if (total[SAMPLE_W]) res = '1;
    else                 res = total[SAMPLE_W-1:0];
    return res;
  endfunction

  pwm_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk  (hwclk),
    .i_nrst (nrst),
    .i_pin  (pwm_in),
    .o_s    (w_s),
    .o_rise (w_rise)
  );

  always_ff @(posedge hwclk) begin
    if (!nrst) r_state <= DEC_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (!enable) begin
      w_next_state = DEC_IDLE;
    end else begin
      case (r_state)
        DEC_IDLE:  w_next_state = DEC_SEEK;
        DEC_SEEK:  if (w_rise) w_next_state = DEC_TRACK;
        DEC_TRACK: w_next_state = DEC_TRACK;
        default:   w_next_state = DEC_IDLE;
      endcase
    end
  end

  // A frame (re)starts on the seek edge or on a misplaced edge: that cycle is pos 0 with an empty count.
  always_comb begin
    w_active    = enable && ((r_state == DEC_TRACK) || (r_state == DEC_SEEK && w_rise));
    w_restart   = enable && (r_state == DEC_TRACK) && w_rise && (r_pos != '0);
    w_cur_pos   = (w_restart || r_state == DEC_SEEK) ? '0 : r_pos;
    w_base      = (w_restart || r_state == DEC_SEEK) ? '0 : r_high_cnt;
    w_total     = {1'b0, w_base} + {{SAMPLE_W{1'b0}}, w_s};
    w_frame_end = w_active && (w_cur_pos == SAMPLE_W'(PERIOD - 1));
  end

  always_ff @(posedge hwclk) begin
    if (!nrst) begin
      r_pos      <= '0;
      r_high_cnt <= '0;
      r_sample   <= '0;
      r_valid    <= 1'b0;
      r_locked   <= 1'b0;
      r_perr     <= 1'b0;
    end else if (!enable) begin
      r_pos      <= '0;
      r_high_cnt <= '0;
      r_valid    <= 1'b0;
      r_locked   <= 1'b0;
      r_perr     <= 1'b0;
    end else if (w_active) begin
      r_pos      <= w_cur_pos + SAMPLE_W'(1);
      r_high_cnt <= w_frame_end ? '0 : w_total[SAMPLE_W-1:0];
      r_valid    <= w_frame_end;
      if (w_frame_end) begin
        r_sample <= sat_sample(w_total);
        r_locked <= 1'b1;
      end
      if (w_restart) begin
        r_perr   <= 1'b1;
        r_locked <= 1'b0;
      end
    end else begin
      r_pos      <= '0;
      r_high_cnt <= '0;
      r_valid    <= 1'b0;
    end
  end

  assign sample       = r_sample;
  assign sample_valid = r_valid;
  assign locked       = r_locked;
  assign phase_err    = r_perr;

endmodule

// File: tb/tb_pwm_sample_decoder.sv
// Directed bench for pwm_sample_decoder: frames of known duty are generated and
// their expected samples queued; a monitor compares every strobe against the queue.
module tb_pwm_sample_decoder;

  logic       hwclk = 1'b0;
  logic       nrst = 1'b0;
  logic       enable = 1'b0;
  logic       pwm_in = 1'b0;
  logic [7:0] sample;
  logic       sample_valid, locked, phase_err;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_q[$];
  logic exp_perr = 1'b0;

  always #5 hwclk = ~hwclk;

  pwm_sample_decoder #(.PERIOD(256), .SAMPLE_W(8), .SYNC_STAGES(2)) dut (
    .hwclk        (hwclk),
    .nrst         (nrst),
    .enable       (enable),
    .pwm_in       (pwm_in),
    .sample       (sample),
    .sample_valid (sample_valid),
    .locked       (locked),
    .phase_err    (phase_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // One PWM level per clock; the pin changes just after the rising edge.
  task automatic drive(input int high_n, input int total_n);
    for (int k = 0; k < total_n; k++) begin
      pwm_in = (k < high_n) ? 1'b1 : 1'b0;
      @(posedge hwclk);
      #1;
    end
  endtask

  task automatic frame(input int duty);
    exp_q.push_back((duty > 255) ? 255 : duty);
    drive(duty, 256);
  endtask

  always @(negedge hwclk) begin
    if (sample_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_strobe: got sample %0d, expected no strobe (t=%0t)", sample, $time);
      end else begin
        check("strobe_sample", 32'(sample), exp_q.pop_front());
        check("strobe_locked", 32'(locked), 1);
        check("strobe_phase_err", 32'(phase_err), 32'(exp_perr));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    drive(0, 3);
    check("rst_sample", 32'(sample), 0);
    check("rst_valid", 32'(sample_valid), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_phase_err", 32'(phase_err), 0);
    nrst = 1'b1;
    enable = 1'b1;
    drive(0, 4);

    // Test 1: duty 64 for four frames
    exp_q.push_back(64);
    drive(64, 128);
    check("t1_locked_before_strobe", 32'(locked), 0);
    check("t1_phase_err", 32'(phase_err), 0);
    drive(0, 128);
    frame(64);
    frame(64);
    frame(64);

    // Test 2: 200, then duty 0, then constant high
    frame(200);
    frame(0);
    frame(256);

    // Test 3: extra rise at pos 50 restarts the frame
    frame(100);
    drive(40, 50);
    exp_perr = 1'b1;
    exp_q.push_back(100);
    drive(20, 20);
    check("t3_phase_err", 32'(phase_err), 1);
    check("t3_locked", 32'(locked), 0);
    drive(80, 236);

    // Test 4: enable dropped mid-frame, then re-enabled
    frame(100);
    drive(100, 128);
    enable = 1'b0;
    exp_perr = 1'b0;
    drive(0, 10);
    check("t4_sample_hold", 32'(sample), 100);
    check("t4_locked", 32'(locked), 0);
    check("t4_phase_err", 32'(phase_err), 0);
    enable = 1'b1;
    drive(0, 118);
    frame(100);

    // Test 6: enable drops exactly on the last frame cycle
    drive(150, 256);
    drive(0, 1);
    enable = 1'b0;
    drive(0, 1);
    drive(0, 5);
    check("t6_sample_hold", 32'(sample), 100);
    check("t6_locked", 32'(locked), 0);
    enable = 1'b1;
    drive(0, 247);

    // Test 5: one-cycle reset mid-frame
    frame(100);
    drive(100, 200);
    nrst = 1'b0;
    drive(0, 1);
    nrst = 1'b1;
    check("t5_sample", 32'(sample), 0);
    check("t5_valid", 32'(sample_valid), 0);
    check("t5_locked", 32'(locked), 0);
    check("t5_phase_err", 32'(phase_err), 0);
    drive(0, 55);
    frame(77);
    drive(0, 10);

    check("pending_strobes", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
